mips16_exec_unit: RTL and testbench

Combined decode, execute and data-memory block for the 16-bit, 5-stage MIPS-style processor. It decodes the 4-bit opcode into datapath control signals and runs the 16-bit ALU with flag outputs. It also holds the 64×16 data memory that load/store instructions access. The pipeline stages around it supply register operands and the sign-extended immediate, and consume its results for writeback and PC selection.

---
 rtl/mips16_pkg.sv | 40 ++++
 rtl/mips16_exec_unit_alu16.sv | 53 +++++
 rtl/mips16_exec_unit.sv | 98 +++++++++
 tb/tb_mips16_exec_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared constants and decoded-control type for the 16-bit MIPS-style execute unit.
package mips16_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SRL  = 4'd11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam int DMEM_DEPTH = 64;
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdest;
    logic       branch;
    logic       alusrc;
    logic [2:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mips16_exec_unit_alu16.sv
// 16-bit ALU with signed-compare, zero and overflow flags.
// Shifts exist only when ALU_SHIFT_EN is defined; otherwise shift aluops yield 0.
module alu16
  import mips16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  aluop,
  output logic [15:0] result,
  output logic        slt,
  output logic        zero,
  output logic        gt,
  output logic        ov
);

  logic lt;
  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (aluop)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {15'b0, lt};
      ALU_XOR: result = a ^ b;
`ifdef ALU_SHIFT_EN
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
`else
      ALU_SLL: result = '0;
      ALU_SRL: result = '0;
`endif
      default: result = '0;
    endcase
  end

  assign slt  = lt;
  assign gt   = $signed(a) > $signed(b);
  assign zero = (result == 16'h0000);

  // Overflow: result sign differs from A when operand signs make it impossible.
  always_comb begin
    ov = 1'b0;
    case (aluop)
      ALU_ADD: ov = (a[15] == b[15]) && (result[15] != a[15]);
      ALU_SUB: ov = (a[15] != b[15]) && (result[15] != a[15]);
      default: ov = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips16_exec_unit.sv
// Decode, ALU and 64x16 data memory for the 16-bit MIPS-style pipeline.
// Optional feature macro: ALU_SHIFT_EN enables SLL/SRL decode for opcodes 10/11.
module mips16_exec_unit
  import mips16_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic [3:0]  opcode,
  input  logic [15:0] rs_data,
  input  logic [15:0] rt_data,
  input  logic [15:0] imm,
  output logic        alusrc,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        regdest,
  output logic        branch,
  output logic [2:0]  aluop,
  output logic [15:0] alu_out,
  output logic        slt,
  output logic        zero,
  output logic        gt,
  output logic        ov,
  output logic        branch_taken,
  output logic [15:0] mem_rdata
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ADD:  begin ctrl.regwrite = 1'b1; ctrl.regdest = 1'b1; ctrl.aluop = ALU_ADD; end
      OP_SUB:  begin ctrl.regwrite = 1'b1; ctrl.regdest = 1'b1; ctrl.aluop = ALU_SUB; end
      OP_AND:  begin ctrl.regwrite = 1'b1; ctrl.regdest = 1'b1; ctrl.aluop = ALU_AND; end
      OP_OR:   begin ctrl.regwrite = 1'b1; ctrl.regdest = 1'b1; ctrl.aluop = ALU_OR;  end
      OP_SLT:  begin ctrl.regwrite = 1'b1; ctrl.regdest = 1'b1; ctrl.aluop = ALU_SLT; end
      OP_ADDI: begin ctrl.regwrite = 1'b1; ctrl.alusrc  = 1'b1; ctrl.aluop = ALU_ADD; end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      OP_SW:   begin ctrl.alusrc = 1'b1; ctrl.memwrite = 1'b1; ctrl.aluop = ALU_ADD; end
      OP_BNE:  begin ctrl.branch = 1'b1; ctrl.aluop = ALU_SUB; end
      OP_XOR:  begin ctrl.regwrite = 1'b1; ctrl.regdest = 1'b1; ctrl.aluop = ALU_XOR; end
`ifdef ALU_SHIFT_EN
      OP_SLL:  begin ctrl.regwrite = 1'b1; ctrl.regdest = 1'b1; ctrl.aluop = ALU_SLL; end
      OP_SRL:  begin ctrl.regwrite = 1'b1; ctrl.regdest = 1'b1; ctrl.aluop = ALU_SRL; end
`endif
      default: ctrl = '0;
    endcase
  end

  assign regwrite = ctrl.regwrite;
  assign memread  = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign memtoreg = ctrl.memtoreg;
  assign regdest  = ctrl.regdest;
  assign branch   = ctrl.branch;
  assign alusrc   = ctrl.alusrc;
  assign aluop    = ctrl.aluop;

  logic [15:0] alu_b;
  assign alu_b = ctrl.alusrc ? imm : rt_data;

  alu16 u_alu (
    .a      (rs_data),
    .b      (alu_b),
    .aluop  (ctrl.aluop),
    .result (alu_out),
    .slt    (slt),
    .zero   (zero),
    .gt     (gt),
    .ov     (ov)
  );

  assign branch_taken = ctrl.branch & (rs_data != rt_data);

  // Word address uses only the low bits, so higher addresses alias.
  logic [15:0]        mem [DMEM_DEPTH];
  logic [DMEM_AW-1:0] addr;
  assign addr = alu_out[DMEM_AW-1:0];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
    end else if (ctrl.memwrite) begin
      mem[addr] <= rt_data;
    end
  end

  assign mem_rdata = ctrl.memread ? mem[addr] : 16'h0000;

endmodule

// File: tb/tb_mips16_exec_unit.sv
// Directed table-driven bench for mips16_exec_unit plus memory/clear sequences.
module tb_mips16_exec_unit;

  logic        clk = 1'b0;
  logic        clear;
  logic [3:0]  opcode;
  logic [15:0] rs_data, rt_data, imm;
  logic        alusrc, regwrite, memread, memwrite, memtoreg, regdest, branch;
  logic [2:0]  aluop;
  logic [15:0] alu_out, mem_rdata;
  logic        slt, zero, gt, ov, branch_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips16_exec_unit dut (
    .clk          (clk),
    .clear        (clear),
    .opcode       (opcode),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .imm          (imm),
    .alusrc       (alusrc),
    .regwrite     (regwrite),
    .memread      (memread),
    .memwrite     (memwrite),
    .memtoreg     (memtoreg),
    .regdest      (regdest),
    .branch       (branch),
    .aluop        (aluop),
    .alu_out      (alu_out),
    .slt          (slt),
    .zero         (zero),
    .gt           (gt),
    .ov           (ov),
    .branch_taken (branch_taken),
    .mem_rdata    (mem_rdata)
  );

  // ctrl order: {regwrite, memread, memwrite, memtoreg, regdest, branch, alusrc, aluop}
  localparam logic [9:0] C_NOP  = 10'b0000000_000;
  localparam logic [9:0] C_ADD  = 10'b1000100_000;
  localparam logic [9:0] C_SUB  = 10'b1000100_001;
  localparam logic [9:0] C_AND  = 10'b1000100_010;
  localparam logic [9:0] C_OR   = 10'b1000100_011;
  localparam logic [9:0] C_SLT  = 10'b1000100_100;
  localparam logic [9:0] C_XOR  = 10'b1000100_101;
  localparam logic [9:0] C_SLL  = 10'b1000100_110;
  localparam logic [9:0] C_SRL  = 10'b1000100_111;
  localparam logic [9:0] C_ADDI = 10'b1000001_000;
  localparam logic [9:0] C_LW   = 10'b1101001_000;
  localparam logic [9:0] C_SW   = 10'b0010001_000;
  localparam logic [9:0] C_BNE  = 10'b0000010_001;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] rs, rt, im;
    logic [15:0] alu;
    logic [9:0]  ctl;
    logic [3:0]  flg;   // {slt, zero, gt, ov}
    logic        bt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] act_ctrl();
    return {regwrite, memread, memwrite, memtoreg, regdest, branch, alusrc, aluop};
  endfunction

  task automatic add_vec(input string nm, input logic [3:0] op, input logic [15:0] rs,
                         input logic [15:0] rt, input logic [15:0] im, input logic [15:0] alu,
                         input logic [9:0] ctl, input logic [3:0] flg, input logic bt);
    vec_t v;
    v.name = nm; v.op = op; v.rs = rs; v.rt = rt; v.im = im;
    v.alu = alu; v.ctl = ctl; v.flg = flg; v.bt = bt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] rs, input logic [15:0] rt,
                       input logic [15:0] im);
    opcode = op; rs_data = rs; rt_data = rt; imm = im;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    add_vec("add_ovf",  4'd0,  16'h7FFF, 16'h0001, 16'h0000, 16'h8000, C_ADD,  4'b0011, 1'b0);
    add_vec("sub_zero", 4'd1,  16'h0005, 16'h0005, 16'h0000, 16'h0000, C_SUB,  4'b0100, 1'b0);
    add_vec("slt_neg",  4'd4,  16'hFFFF, 16'h0001, 16'h0000, 16'h0001, C_SLT,  4'b1000, 1'b0);
    add_vec("and",      4'd2,  16'hF0F0, 16'h3C3C, 16'h0000, 16'h3030, C_AND,  4'b1000, 1'b0);
    add_vec("or",       4'd3,  16'h1200, 16'h0034, 16'h0000, 16'h1234, C_OR,   4'b0010, 1'b0);
    add_vec("xor_zero", 4'd9,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, C_XOR,  4'b0100, 1'b0);
    add_vec("addi_neg", 4'd5,  16'h0010, 16'h1234, 16'hFFFE, 16'h000E, C_ADDI, 4'b0010, 1'b0);
    add_vec("sub_ovf",  4'd1,  16'h8000, 16'h0001, 16'h0000, 16'h7FFF, C_SUB,  4'b1001, 1'b0);
    add_vec("bne_eq",   4'd8,  16'h0004, 16'h0004, 16'h0000, 16'h0000, C_BNE,  4'b0100, 1'b0);
    add_vec("bne_ne",   4'd8,  16'h0004, 16'h0005, 16'h0000, 16'hFFFF, C_BNE,  4'b1000, 1'b1);
    add_vec("nop12",    4'd12, 16'h0003, 16'h0005, 16'h0000, 16'h0008, C_NOP,  4'b1000, 1'b0);
    add_vec("nop15",    4'd15, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, C_NOP,  4'b1100, 1'b0);
`ifdef ALU_SHIFT_EN
    add_vec("sll",      4'd10, 16'h0001, 16'h0004, 16'h0000, 16'h0010, C_SLL,  4'b1000, 1'b0);
    add_vec("srl",      4'd11, 16'h8000, 16'h0004, 16'h0000, 16'h0800, C_SRL,  4'b1000, 1'b0);
`else
    add_vec("op10_nop", 4'd10, 16'h0001, 16'h0004, 16'h0000, 16'h0005, C_NOP,  4'b1000, 1'b0);
    add_vec("op11_nop", 4'd11, 16'h8000, 16'h0004, 16'h0000, 16'h8004, C_NOP,  4'b1000, 1'b0);
`endif

    // Reset: every word reads back zero.
    clear = 1'b1;
    drive(4'd12, 16'h0000, 16'h0000, 16'h0000);
    tick();
    clear = 1'b0;
    drive(4'd6, 16'h0000, 16'h0000, 16'h0000);
    chk("rst_mem0", mem_rdata, 16'h0000);
    drive(4'd6, 16'h0003, 16'h0000, 16'h0000);
    chk("rst_mem3", mem_rdata, 16'h0000);
    drive(4'd6, 16'h003F, 16'h0000, 16'h0000);
    chk("rst_mem63", mem_rdata, 16'h0000);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].im);
      chk({vecs[i].name, "_alu"},  alu_out, vecs[i].alu);
      chk({vecs[i].name, "_ctrl"}, {6'b0, act_ctrl()}, {6'b0, vecs[i].ctl});
      chk({vecs[i].name, "_flag"}, {12'b0, slt, zero, gt, ov}, {12'b0, vecs[i].flg});
      chk({vecs[i].name, "_bt"},   {15'b0, branch_taken}, {15'b0, vecs[i].bt});
      chk({vecs[i].name, "_rdat"}, mem_rdata, 16'h0000);
    end

    // SW BEEF to address 5, then LW back (also via aliased address 0x45).
    drive(4'd7, 16'h0002, 16'hBEEF, 16'h0003);
    chk("sw_ctrl", {6'b0, act_ctrl()}, {6'b0, C_SW});
    chk("sw_addr", alu_out, 16'h0005);
    chk("sw_rdat", mem_rdata, 16'h0000);
    tick();
    drive(4'd6, 16'h0002, 16'h0000, 16'h0003);
    chk("lw_ctrl", {6'b0, act_ctrl()}, {6'b0, C_LW});
    chk("lw_rdat", mem_rdata, 16'hBEEF);
    chk("lw_memtoreg", {15'b0, memtoreg}, 16'h0001);
    drive(4'd6, 16'h0045, 16'h0000, 16'h0000);
    chk("lw_alias", mem_rdata, 16'hBEEF);
    drive(4'd12, 16'h0002, 16'h0000, 16'h0003);
    chk("nop_rdat_gated", mem_rdata, 16'h0000);

    // Top word, then confirm neighbour untouched.
    drive(4'd7, 16'h003F, 16'h1234, 16'h0000);
    tick();
    drive(4'd6, 16'h003F, 16'h0000, 16'h0000);
    chk("lw_63", mem_rdata, 16'h1234);
    drive(4'd6, 16'h0005, 16'h0000, 16'h0000);
    chk("lw_5_kept", mem_rdata, 16'hBEEF);

    // Overwrite: old data held until the edge.
    drive(4'd7, 16'h0005, 16'h5A5A, 16'h0000);
    drive(4'd6, 16'h0005, 16'h0000, 16'h0000);
    chk("pre_edge_old", mem_rdata, 16'hBEEF);
    drive(4'd7, 16'h0005, 16'h5A5A, 16'h0000);
    tick();
    drive(4'd6, 16'h0005, 16'h0000, 16'h0000);
    chk("post_edge_new", mem_rdata, 16'h5A5A);

    // Clear wins over a simultaneous store to address 3.
    clear = 1'b1;
    drive(4'd7, 16'h0003, 16'hAAAA, 16'h0000);
    tick();
    clear = 1'b0;
    drive(4'd6, 16'h0000, 16'h0000, 16'h0003);
    chk("clr_vs_sw3", mem_rdata, 16'h0000);
    drive(4'd6, 16'h0005, 16'h0000, 16'h0000);
    chk("clr_mem5", mem_rdata, 16'h0000);
    drive(4'd6, 16'h003F, 16'h0000, 16'h0000);
    chk("clr_mem63", mem_rdata, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
